// File: rtl/pipelined_cla_addsub_if.sv
// rtl/pipelined_cla_addsub_if.sv - operation/result handshake bundle for pipelined_cla_addsub
//
// Purpose: groups the input-operation channel and the result channel of the
// pipelined adder/subtractor so producer and consumer connect as one bundle.
//
// Signals:
//   in_valid, in_ready          operation handshake (in_ready driven by the adder)
//   a, b, cin, sub, in_tag      operation payload
//   out_valid, out_ready        result handshake (out_ready driven by the consumer)
//   sum, cout, ovf, zero, out_tag  result payload
//
// Modports:
//   master  the side that issues operations and consumes results
//   slave   the adder itself
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 64,
  parameter int TAGW  = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [TAGW-1:0]  in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [TAGW-1:0]  out_tag;

  modport master (
    output in_valid, a, b, cin, sub, in_tag, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, out_tag
  );

  modport slave (
    input  in_valid, a, b, cin, sub, in_tag, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, out_tag
  );

endinterface

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined carry-lookahead adder/subtractor with valid/ready flow control
//
// Purpose: computes A+B+cin or A-B-cin over WIDTH bits, resolving one BLOCK-bit
// slice per pipeline stage with 4-bit-group generate/propagate lookahead.
// Bank 0 registers the accepted operation (operands already in effective form);
// stage k resolves slice k from bank k into bank k+1, so a result appears NSTG
// cycles after its input transfer. One global enable stalls the whole pipe.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; clears every valid bit and the outputs
//   bus   pipelined_cla_addsub_if.slave: in_valid/in_ready/a/b/cin/sub/in_tag in,
//         out_valid/out_ready/sum/cout/ovf/zero/out_tag out
module pipelined_cla_addsub #(
  parameter int WIDTH = 64,
  parameter int BLOCK = 16,
  parameter int TAGW  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pipelined_cla_addsub_if.slave   bus
);

  localparam int NSTG = WIDTH / BLOCK;

  generate
    if ((BLOCK < 4) || ((WIDTH % BLOCK) != 0)) begin : g_param_check
      $error("pipelined_cla_addsub: WIDTH must be a multiple of BLOCK and BLOCK >= 4");
    end
  endgenerate

  // One BLOCK-bit slice: carries inside each 4-bit group are written in
  // lookahead form from the group carry-in; group generate/propagate then
  // produce the carry into the next group. Returns {carry_out, sum}.
  function automatic logic [BLOCK:0] cla_block(
    input logic [BLOCK-1:0] x,
    input logic [BLOCK-1:0] y,
    input logic             ci
  );
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] s;
    logic             cg;
    logic             cj;
    logic             pc;
    logic             gg;
    int               gsz;
    g  = x & y;
    p  = x ^ y;
    s  = '0;
    cg = ci;
    for (int base = 0; base < BLOCK; base += 4) begin
      gsz = ((BLOCK - base) < 4) ? (BLOCK - base) : 4;
      for (int j = 0; j < 4; j++) begin
        if (j < gsz) begin
          cj = 1'b0;
          pc = 1'b1;
          for (int i = j - 1; i >= 0; i--) begin
            cj = cj | (g[base+i] & pc);
            pc = pc & p[base+i];
          end
          s[base+j] = p[base+j] ^ (cj | (pc & cg));
        end
      end
      gg = 1'b0;
      pc = 1'b1;
      for (int i = 3; i >= 0; i--) begin
        if (i < gsz) begin
          gg = gg | (g[base+i] & pc);
          pc = pc & p[base+i];
        end
      end
      cg = gg | (pc & cg);
    end
    return {cg, s};
  endfunction

  // Bank k feeds stage k; bank NSTG is the output register.
  logic [WIDTH-1:0] a_q     [0:NSTG];
  logic [WIDTH-1:0] beff_q  [0:NSTG];
  logic [WIDTH-1:0] sum_q   [0:NSTG];
  logic             carry_q [0:NSTG];
  logic [TAGW-1:0]  tag_q   [0:NSTG];
  logic             vld_q   [0:NSTG];

  logic [BLOCK:0]   blk_res [0:NSTG-1];
  logic [WIDTH-1:0] final_sum;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             en;

  // A result sitting unaccepted freezes everything, bubbles included.
  assign en           = !(vld_q[NSTG] && !bus.out_ready);
  assign bus.in_ready = en;

  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      blk_res[k] = cla_block(a_q[k][k*BLOCK +: BLOCK],
                             beff_q[k][k*BLOCK +: BLOCK],
                             carry_q[k]);
    end
    final_sum = sum_q[NSTG-1];
    final_sum[WIDTH-BLOCK +: BLOCK] = blk_res[NSTG-1][BLOCK-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= NSTG; k++) begin
        vld_q[k]   <= 1'b0;
        tag_q[k]   <= '0;
        a_q[k]     <= '0;
        beff_q[k]  <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      // Subtraction is A + ~B + !cin, so the borrow-in folds into the carry.
      vld_q[0]   <= bus.in_valid;
      tag_q[0]   <= bus.in_tag;
      a_q[0]     <= bus.a;
      beff_q[0]  <= bus.sub ? ~bus.b : bus.b;
      carry_q[0] <= bus.cin ^ bus.sub;
      sum_q[0]   <= '0;
      for (int k = 0; k < NSTG; k++) begin
        vld_q[k+1]   <= vld_q[k];
        tag_q[k+1]   <= tag_q[k];
        a_q[k+1]     <= a_q[k];
        beff_q[k+1]  <= beff_q[k];
        carry_q[k+1] <= blk_res[k][BLOCK];
        sum_q[k+1]   <= sum_q[k];
        sum_q[k+1][k*BLOCK +: BLOCK] <= blk_res[k][BLOCK-1:0];
      end
      cout_q <= blk_res[NSTG-1][BLOCK];
      ovf_q  <= (a_q[NSTG-1][WIDTH-1] == beff_q[NSTG-1][WIDTH-1]) &&
                (final_sum[WIDTH-1] != a_q[NSTG-1][WIDTH-1]);
      zero_q <= (final_sum == '0);
    end
  end

  assign bus.out_valid = vld_q[NSTG];
  assign bus.sum       = sum_q[NSTG];
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.out_tag   = tag_q[NSTG];

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - scoreboard bench for pipelined_cla_addsub
module tb_pipelined_cla_addsub;

  localparam int WIDTH = 64;
  localparam int BLOCK = 16;
  localparam int TAGW  = 4;
  localparam int NSTG  = WIDTH / BLOCK;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
    int          issue;
    bit          exact;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   exact_mode = 1'b1;
  bit   tog_done = 1'b0;
  exp_t sbq[$];
  exp_t mon_e;

  pipelined_cla_addsub_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus ();

  pipelined_cla_addsub #(.WIDTH(WIDTH), .BLOCK(BLOCK), .TAGW(TAGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on widened operands.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub, input logic [3:0] tag);
    exp_t r;
    logic [64:0]        u;
    logic signed [65:0] sa;
    logic signed [65:0] sbv;
    logic signed [65:0] sr;
    logic signed [65:0] mx;
    logic signed [65:0] mn;
    sa  = $signed({{2{a[63]}}, a});
    sbv = $signed({{2{b[63]}}, b});
    mx  = 66'sd9223372036854775807;
    mn  = -mx - 66'sd1;
    if (sub) begin
      u      = {1'b0, a} - {1'b0, b} - {64'b0, cin};
      sr     = sa - sbv - $signed({65'b0, cin});
      r.cout = ~u[64];
    end else begin
      u      = {1'b0, a} + {1'b0, b} + {64'b0, cin};
      sr     = sa + sbv + $signed({65'b0, cin});
      r.cout = u[64];
    end
    r.sum   = u[63:0];
    r.zero  = (u[63:0] == 64'd0);
    r.ovf   = (sr > mx) || (sr < mn);
    r.tag   = tag;
    r.issue = 0;
    r.exact = 1'b0;
    return r;
  endfunction

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Entered and left just after a rising edge; holds the operation until accepted.
  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic cin, input logic sub, input logic [3:0] tag);
    exp_t e;
    bit   done;
    done         = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e       = model(a, b, cin, sub, tag);
        e.issue = cyc;
        e.exact = exact_mode;
        sbq.push_back(e);
        done    = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready never asserted for tag %0d", tag);
    end
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int t = 0; t < 200 && sbq.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    if (sbq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results never delivered", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic reset_checks();
    check("rst_out_valid", 71'(bus.out_valid), 71'(0));
    check("rst_sum",       71'(bus.sum),       71'(0));
    check("rst_cout",      71'(bus.cout),      71'(0));
    check("rst_ovf",       71'(bus.ovf),       71'(0));
    check("rst_zero",      71'(bus.zero),      71'(0));
    check("rst_out_tag",   71'(bus.out_tag),   71'(0));
    check("rst_in_ready",  71'(bus.in_ready),  71'(1));
  endtask

  // Monitor: every presented result is compared with the oldest expectation,
  // repeatedly while stalled, and popped only when it transfers.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready_rule", 71'(bus.in_ready), 71'(!(bus.out_valid && !bus.out_ready)));
      if (bus.out_valid) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: sum=%h tag=%0d with nothing outstanding", bus.sum, bus.out_tag);
        end else begin
          mon_e = sbq[0];
          check("result", {bus.sum, bus.cout, bus.ovf, bus.zero, bus.out_tag},
                {mon_e.sum, mon_e.cout, mon_e.ovf, mon_e.zero, mon_e.tag});
          if (bus.out_ready) begin
            if (mon_e.exact) check("latency", 71'(cyc - mon_e.issue - 1), 71'(NSTG));
            void'(sbq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m16;
    logic [63:0] m32;
    logic [63:0] one;
    m16 = 64'hFFFF;
    m32 = 64'hFFFF_FFFF;
    one = 64'd1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    rst = 1'b1;
    @(posedge clk);
    #1;
    reset_checks();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors, first one issued on the first edge after reset release.
    exact_mode = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'd3);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'd5);
    send(64'd5, 64'd7, 1'b0, 1'b1, 4'd6);
    send(64'd0, 64'd0, 1'b1, 1'b1, 4'd7);
    for (int j = 0; j < 4; j++) send(m16 << (16 * j), one << (16 * j), 1'b0, 1'b0, 4'(j));
    for (int j = 0; j < 3; j++) send(m32 << (16 * j), one << (16 * j), 1'b0, 1'b0, 4'(8 + j));
    for (int j = 0; j < 3; j++) send(one << (16 * (j + 1)), 64'd1, 1'b0, 1'b1, 4'(12 + j));
    drain();

    // Ten back-to-back random operations.
    for (int i = 0; i < 10; i++)
      send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
    drain();

    // Fill the pipe with the consumer stalled, hold five cycles, then release.
    exact_mode    = 1'b0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
        bus.in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 50 && !bus.out_valid; t++) @(negedge clk);
        check("stall_fill_out_valid", 71'(bus.out_valid), 71'(1));
        repeat (5) @(negedge clk);
        check("stall_in_ready", 71'(bus.in_ready), 71'(0));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with input gaps and random consumer back-pressure.
    tog_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
        end
        bus.in_valid = 1'b0;
        tog_done     = 1'b1;
      end
      begin
        while (!tog_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Reset with three operations in flight.
    exact_mode = 1'b1;
    for (int i = 0; i < 3; i++)
      send(rnd_op(), rnd_op(), 1'b0, 1'($urandom_range(0, 1)), 4'(i));
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    reset_checks();
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'd3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
